// File: rtl/wdt_ice_counter.sv
// ---------------------------------------------------------------------------
// wdt_ice_counter
//
// Watchdog timer counter for the ICE environment. The gated 15 kHz WDT clock
// (LOSCOUT) is synchronised into the 30 MHz domain and edge-detected into a
// one-cycle tick. While running, each tick advances an 18-bit counter. At
// 3N/4 an optional interval interrupt pulses. At N-1 the next tick raises a
// sticky reset request and parks the block in OVF until power-on reset.
// N = 2^(10+WDCS), sampled only when the counter starts running.
//
// Ports
//   CLK30MHZ   in   1   system clock, rising edge
//   PONRESB    in   1   power-on reset, asynchronous, active-low
//   LOSCOUT    in   1   WDT clock, asynchronous to CLK30MHZ
//   WDTE       in   1   run enable (level)
//   WDCS       in   3   overflow select
//   WDTINTEN   in   1   interval interrupt enable
//   WDTCLR     in   1   counter clear request (one-cycle pulse)
//   WDTCNT     out  18  current count
//   WDTINT     out  1   interval interrupt, one-cycle pulse
//   WDTRESREQ  out  1   overflow reset request, sticky
//   WDTST      out  2   state: 00 STOP, 01 RUN, 10 OVF
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module wdt_ice_counter (
    input  logic        CLK30MHZ,
    input  logic        PONRESB,
    input  logic        LOSCOUT,
    input  logic        WDTE,
    input  logic [2:0]  WDCS,
    input  logic        WDTINTEN,
    input  logic        WDTCLR,
    output logic [17:0] WDTCNT,
    output logic        WDTINT,
    output logic        WDTRESREQ,
    output logic [1:0]  WDTST
);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVF  = 2'b10
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        s1, s2, s3;
    logic        fill;
    logic        armed;
    logic        tick;

    logic [2:0]  wdcs_l;
    logic [2:0]  wdcs_nxt;
    logic [17:0] count;
    logic [17:0] count_nxt;
    logic        int_nxt;
    logic        resreq_nxt;

    logic [4:0]  shamt;
    logic [17:0] last_cnt;
    logic [17:0] int_prev;
    logic        at_last;

    // -----------------------------------------------------------------------
    // LOSCOUT synchroniser and rising-edge detect.
    // The synchroniser flops reset to 0, so a LOSCOUT that is already high at
    // release would look like a rising edge. 'armed' blocks ticks until a real
    // low sample has passed through s1. 'fill' marks that s1 holds a real
    // sample rather than its reset value.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its source.
    always_ff @(posedge CLK30MHZ or negedge PONRESB) begin
        if (!PONRESB) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            fill  <= 1'b0;
            armed <= 1'b0;
        end else begin
            s1    <= LOSCOUT;
            s2    <= s1;
            s3    <= s2;
            fill  <= 1'b1;
            armed <= armed | (fill & ~s1);
        end
    end

    assign tick = s2 & ~s3 & armed;

    // Period limits from the latched select: N = 4 << (8+wdcs_l), 3N/4 = 3 << (8+wdcs_l).
    assign shamt    = 5'd8 + 5'(wdcs_l);
    assign last_cnt = (18'd4 << shamt) - 18'd1;
    assign int_prev = (18'd3 << shamt) - 18'd1;
    assign at_last  = (count >= last_cnt);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK30MHZ or negedge PONRESB) begin
        if (!PONRESB) begin
            state <= ST_STOP;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_STOP: if (WDTE) state_nxt = ST_RUN;
            ST_RUN: begin
                if (!WDTE) begin
                    state_nxt = ST_STOP;
                end else if (tick && !WDTCLR && at_last) begin
                    state_nxt = ST_OVF;
                end
            end
            ST_OVF:  state_nxt = ST_OVF;   // only PONRESB leaves OVF
            default: state_nxt = ST_STOP;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / datapath next values (registered below)
    // Priority in RUN: disable, then clear, then tick.
    // -----------------------------------------------------------------------
    always_comb begin
        count_nxt  = count;
        wdcs_nxt   = wdcs_l;
        int_nxt    = 1'b0;
        resreq_nxt = WDTRESREQ;
        unique case (state)
            ST_STOP: begin
                if (WDTE) begin
                    wdcs_nxt  = WDCS;
                    count_nxt = '0;
                end
            end
            ST_RUN: begin
                if (!WDTE || WDTCLR) begin
                    count_nxt = '0;
                end else if (tick) begin
                    if (at_last) begin
                        count_nxt  = '0;
                        resreq_nxt = 1'b1;
                    end else begin
                        count_nxt = count + 18'd1;
                        int_nxt   = WDTINTEN && (count == int_prev);
                    end
                end
            end
            ST_OVF:  count_nxt = '0;
            default: count_nxt = '0;
        endcase
    end

    always_ff @(posedge CLK30MHZ or negedge PONRESB) begin
        if (!PONRESB) begin
            count     <= '0;
            wdcs_l    <= '0;
            WDTINT    <= 1'b0;
            WDTRESREQ <= 1'b0;
        end else begin
            count     <= count_nxt;
            wdcs_l    <= wdcs_nxt;
            WDTINT    <= int_nxt;
            WDTRESREQ <= resreq_nxt;
        end
    end

    assign WDTCNT = count;
    assign WDTST  = state;

endmodule

// File: tb/tb_wdt_ice_counter.sv
// ---------------------------------------------------------------------------
// tb_wdt_ice_counter
//
// Scoreboard bench for wdt_ice_counter. Each stimulus task advances a small
// behavioural model of the watchdog, pushes the expected outputs to a queue,
// drives the stimulus, then pops and compares once the DUT has updated.
// Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_wdt_ice_counter;

    localparam logic [1:0] ST_STOP = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_OVF  = 2'b10;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        loscout  = 1'b0;
    logic        wdte     = 1'b0;
    logic [2:0]  wdcs     = 3'd0;
    logic        inten    = 1'b1;
    logic        wdtclr   = 1'b0;
    logic [17:0] wdtcnt;
    logic        wdtint;
    logic        resreq;
    logic [1:0]  wdtst;

    wdt_ice_counter dut (
        .CLK30MHZ  (clk),
        .PONRESB   (rst_n),
        .LOSCOUT   (loscout),
        .WDTE      (wdte),
        .WDCS      (wdcs),
        .WDTINTEN  (inten),
        .WDTCLR    (wdtclr),
        .WDTCNT    (wdtcnt),
        .WDTINT    (wdtint),
        .WDTRESREQ (resreq),
        .WDTST     (wdtst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] cnt;
        logic        intr;
        logic        resreq;
        logic [1:0]  st;
    } exp_t;

    exp_t sb_q[$];

    int checks   = 0;
    int failures = 0;

    // behavioural model
    int         m_cnt    = 0;
    int         m_n      = 1024;
    logic [1:0] m_st     = ST_STOP;
    logic       m_resreq = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic intr);
        exp_t e;
        e.cnt    = 18'(m_cnt);
        e.intr   = intr;
        e.resreq = m_resreq;
        e.st     = m_st;
        sb_q.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        check({tag, ".sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, ".cnt"},    32'(wdtcnt), 32'(e.cnt));
            check({tag, ".int"},    32'(wdtint), 32'(e.intr));
            check({tag, ".resreq"}, 32'(resreq), 32'(e.resreq));
            check({tag, ".st"},     32'(wdtst),  32'(e.st));
        end
    endtask

    // One LOSCOUT pulse; optionally WDTCLR in the same cycle the tick is seen.
    task automatic send_tick(input bit clr);
        logic intr;
        intr = 1'b0;
        if (m_st == ST_RUN) begin
            if (clr) begin
                m_cnt = 0;
            end else if (m_cnt == m_n - 1) begin
                m_cnt    = 0;
                m_st     = ST_OVF;
                m_resreq = 1'b1;
            end else begin
                m_cnt = m_cnt + 1;
                intr  = inten && (m_cnt == (3 * m_n) / 4);
            end
        end
        push_exp(intr);
        @(negedge clk);
        check("int_one_cycle", 32'(wdtint), 32'd0);
        loscout = 1'b1;          // sampled high at edge k
        @(negedge clk);
        loscout = 1'b0;          // tick high during cycle after edge k+1
        @(negedge clk);
        if (clr) wdtclr = 1'b1;  // collides with the tick
        @(negedge clk);          // counter updated at edge k+2
        wdtclr = 1'b0;
        compare_out(clr ? "tick_clr" : "tick");
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) send_tick(1'b0);
    endtask

    task automatic clear_only();
        if (m_st == ST_RUN) m_cnt = 0;
        push_exp(1'b0);
        @(negedge clk);
        wdtclr = 1'b1;
        @(negedge clk);
        wdtclr = 1'b0;
        compare_out("clear");
    endtask

    task automatic set_wdte(input logic v);
        if (m_st == ST_STOP && v) begin
            m_st  = ST_RUN;
            m_cnt = 0;
            m_n   = 1 << (10 + int'(wdcs));
        end else if (m_st == ST_RUN && !v) begin
            m_st  = ST_STOP;
            m_cnt = 0;
        end
        push_exp(1'b0);
        @(negedge clk);
        wdte = v;
        @(negedge clk);
        compare_out("wdte");
    endtask

    // Mid-cycle reset pulse; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async.cnt",    32'(wdtcnt), 32'd0);
        check("rst_async.int",    32'(wdtint), 32'd0);
        check("rst_async.resreq", 32'(resreq), 32'd0);
        check("rst_async.st",     32'(wdtst),  32'd0);
        m_st     = ST_STOP;
        m_cnt    = 0;
        m_resreq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        if (wdte) begin
            m_st = ST_RUN;
            m_n  = 1 << (10 + int'(wdcs));
        end
        push_exp(1'b0);
        @(negedge clk);
        compare_out("rst_release");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        // Power-on reset state
        #12;
        check("por.cnt",    32'(wdtcnt), 32'd0);
        check("por.int",    32'(wdtint), 32'd0);
        check("por.resreq", 32'(resreq), 32'd0);
        check("por.st",     32'(wdtst),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // STOP ignores ticks and clears
        send_tick(1'b0);
        clear_only();

        // Basic overflow, N = 1024, interrupt at 767 -> 768
        wdcs  = 3'd0;
        inten = 1'b1;
        set_wdte(1'b1);
        run_ticks(1024);

        // OVF lockout
        set_wdte(1'b0);
        send_tick(1'b0);
        clear_only();
        send_tick(1'b1);
        set_wdte(1'b1);

        // Reset in OVF with WDTE held high: RUN at the first edge
        do_reset();

        // Clear at 500, then a full further 1024 ticks to overflow
        run_ticks(500);
        clear_only();
        run_ticks(1023);
        send_tick(1'b0);

        // Reset in OVF with WDTE low: stays in STOP
        set_wdte(1'b0);
        do_reset();
        send_tick(1'b0);

        // Clear/tick collision at 767
        set_wdte(1'b1);
        run_ticks(767);
        send_tick(1'b1);

        // Stop at 300
        run_ticks(300);
        set_wdte(1'b0);
        send_tick(1'b0);

        // Interrupt disabled: no pulse at 768
        inten = 1'b0;
        set_wdte(1'b1);
        run_ticks(800);
        set_wdte(1'b0);
        inten = 1'b1;

        // WDCS latched at start: change to 7 in RUN, overflow still at 2048
        wdcs = 3'd1;
        set_wdte(1'b1);
        run_ticks(10);
        wdcs = 3'd7;
        run_ticks(2038);

        // Next STOP -> RUN picks up N = 131072
        set_wdte(1'b0);
        do_reset();
        set_wdte(1'b1);
        run_ticks(2100);

        // Reset mid-RUN at 900, WDTE held high, counting restarts from 0
        set_wdte(1'b0);
        wdcs = 3'd0;
        set_wdte(1'b1);
        run_ticks(900);
        do_reset();
        send_tick(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wdt_ice_counter.md
WDT_ICE_COUNTER -- requirements
Module: wdt_ice_counter

Interface
REQ-001 SHALL have port CLK30MHZ  input  1  30 MHz ICE system clock; all flops clock on its rising edge.
REQ-002 SHALL have port PONRESB  input  1  power-on reset; asynchronous assert, active-low.
REQ-003 SHALL have port LOSCOUT  input  1  gated 15 kHz WDT clock from the oscillator emulation macro; asynchronous to CLK30MHZ.
REQ-004 SHALL have port WDTE  input  1  WDT run enable (level).
REQ-005 SHALL have port WDCS  input  3  overflow select; N = 2^(10+WDCS) ticks (1024..131072).
REQ-006 SHALL have port WDTINTEN  input  1  interval interrupt enable.
REQ-007 SHALL have port WDTCLR  input  1  counter clear request, one CLK30MHZ cycle pulse.
REQ-008 SHALL have port WDTCNT  output  18  current count.
REQ-009 SHALL have port WDTINT  output  1  interval interrupt, one-cycle pulse.
REQ-010 SHALL have port WDTRESREQ  output  1  overflow reset request, sticky.
REQ-011 SHALL have port WDTST  output  2  state: 00 STOP, 01 RUN, 10 OVF.
REQ-012 The interface SHALL be fixed as follows: one clock; reset is asynchronous and active-low.

Function
REQ-013 SHALL synchronise LOSCOUT through two flops (s1, s2), delay it one more flop (s3), and define tick = s2 & ~s3.
- LOSCOUT first sampled high at edge k -> tick high in the cycle after edge k+1 -> counter updates at edge k+2.
REQ-014 SHALL implement the FSM with states STOP, RUN and OVF.
REQ-015 STOP -> RUN when WDTE = 1.
- On that edge, SHALL latch WDCS into an internal select register wdcs_l and clear the counter to 0.
REQ-016 RUN -> STOP when WDTE = 0.
- On that edge, SHALL clear the counter to 0.
REQ-017 RUN -> OVF on the edge where tick = 1, WDTCLR = 0 and count = N-1.
- On that edge, SHALL set WDTRESREQ = 1 and set the counter to 0.
REQ-018 OVF SHALL be left only by PONRESB.
- WDTE, WDTCLR and tick SHALL be ignored in OVF.
REQ-019 In RUN, with tick = 1 and WDTCLR = 0, the count SHALL increment by 1.
- N SHALL be taken from wdcs_l only.
- WDCS changes while in RUN SHALL have no effect until the next STOP -> RUN transition.
REQ-020 In RUN, WDTCLR = 1 SHALL clear the count to 0 on the next edge.
- Clear SHALL have priority over a simultaneous tick.
- WDTCLR SHALL be ignored in STOP.
REQ-021 Whenever WDTINTEN = 1, WDTINT SHALL pulse for exactly one cycle on the edge where the count increments from 3N/4-1 to 3N/4.
- No pulse SHALL be generated if a clear wins that cycle.
- At most one pulse SHALL be generated per count period.
REQ-022 Counter width SHALL be 18 bits.
- The count SHALL never exceed N-1.
- No wrap-around SHALL occur in RUN; overflow goes to OVF instead.
REQ-023 WDTCNT SHALL equal the registered count.
REQ-024 WDTST SHALL equal the registered state encoding.
REQ-025 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-026 PONRESB = 0 SHALL asynchronously force the following:
- state = STOP
- count = 0
- wdcs_l = 0
- s1/s2/s3 = 0
- WDTINT = 0
- WDTRESREQ = 0
- WDTCNT = 0
- WDTST = 00
REQ-027 Reset asserted mid-RUN or in OVF SHALL abort immediately.
- After release, the block SHALL stay in STOP until WDTE = 1 is sampled.
- The first tick SHALL require a fresh LOSCOUT rising edge after release.

Verification
REQ-028 Basic overflow:
- Stimulus: WDCS = 0, WDTE = 1, WDTINTEN = 1, 1024 LOSCOUT pulses.
- Required: WDTINT one-cycle pulse as WDTCNT goes 767->768.
- Required: WDTRESREQ = 1 and WDTST = 10 at the 1024th tick.
REQ-029 Clear mid-count:
- Stimulus: WDCS = 0, WDTCLR at WDTCNT = 500.
- Required: WDTCNT = 0 next edge; no WDTRESREQ until a further 1024 ticks.
REQ-030 Clear/tick collision:
- Stimulus: WDTCLR asserted in the same cycle as tick, at WDTCNT = 767.
- Required: WDTCNT = 0; no WDTINT.
REQ-031 WDCS latching:
- Stimulus: start RUN with WDCS = 1, then change WDCS to 7 in RUN.
- Required: overflow at 2048 ticks.
- Stimulus: then STOP -> RUN.
- Required: the new N = 131072 applies.
REQ-032 Stop and OVF lockout:
- Stimulus: WDTE = 0 at WDTCNT = 300.
- Required: WDTST = 00 and WDTCNT = 0; ticks ignored.
- Stimulus: in OVF, toggle WDTE and pulse WDTCLR.
- Required: WDTRESREQ stays 1.
REQ-033 Reset mid-operation:
- Stimulus: PONRESB low at WDTCNT = 900, or in OVF.
- Required: all outputs 0 asynchronously.
- Required: after release with WDTE held 1, RUN entered at the first edge and counting restarts from 0.
